// File: rtl/boot_loader_if.sv
// Byte-stream, RAM write port and core-control bundle of the firmware loader.
// The master side is the loader itself; the slave side is the receiver/RAM/core environment.
interface boot_loader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) ();
   logic                  restart;
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  core_rst_n;
   logic                  done;
   logic                  error;

   modport master (
      input  restart, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, error
   );

   modport slave (
      output restart, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, error
   );
endinterface

// File: rtl/boot_loader.sv
// Firmware loader: takes a length-prefixed byte stream, reassembles words into RAM writes,
// verifies the XOR checksum and holds the core in reset until the image is good.
module boot_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 4096,
   parameter int BASE_ADDR  = 0,
   parameter int BYTE_SWAP  = 0
) (
   input logic           clk,
   input logic           rst,
   boot_loader_if.master bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BCW   = (BYTES > 4) ? $clog2(BYTES) : 2;

   typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERR} state_t;

   state_t                state_q;
   logic [BCW-1:0]        byteCnt_q;
   logic [31:0]           len_q;
   logic [31:0]           count_q;
   logic [31:0]           index_q;
   logic [DATA_WIDTH-1:0] asm_q;
   logic [7:0]            csum_q;
   logic                  inReady_q;
   logic                  memWe_q;
   logic [ADDR_WIDTH-1:0] memAddr_q;
   logic [DATA_WIDTH-1:0] memWdata_q;
   logic                  coreRstN_q;
   logic                  done_q;
   logic                  error_q;

   logic                  accept_d;
   logic [31:0]           header_d;
   logic [DATA_WIDTH-1:0] asm_d;
   logic [7:0]            csum_d;
   logic [ADDR_WIDTH-1:0] addr_d;

   // Header is always little-endian; payload bytes enter from the top (LE) or bottom (swapped).
   always_comb begin
      accept_d = bus.in_valid && inReady_q;
      header_d = {bus.in_data, len_q[31:8]};
      if (BYTE_SWAP != 0)
         asm_d = (asm_q << 8) | DATA_WIDTH'(bus.in_data);
      else
         asm_d = (asm_q >> 8) | (DATA_WIDTH'(bus.in_data) << (DATA_WIDTH - 8));
      csum_d = csum_q ^ bus.in_data;
      addr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(index_q * 32'(BYTES));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LEN;
         byteCnt_q  <= '0;
         len_q      <= '0;
         count_q    <= '0;
         index_q    <= '0;
         asm_q      <= '0;
         csum_q     <= '0;
         inReady_q  <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         coreRstN_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         memWe_q <= 1'b0;
         case (state_q)
            LEN: begin
               inReady_q <= 1'b1;
               if (accept_d) begin
                  len_q <= header_d;
                  if (byteCnt_q == BCW'(3)) begin
                     byteCnt_q <= '0;
                     count_q   <= header_d;
                     index_q   <= '0;
                     if (header_d > 32'(DEPTH)) begin
                        state_q   <= ERR;
                        error_q   <= 1'b1;
                        inReady_q <= 1'b0;
                     end else if (header_d == 32'd0) begin
                        state_q <= CSUM;
                     end else begin
                        state_q <= DATA;
                     end
                  end else begin
                     byteCnt_q <= byteCnt_q + 1'b1;
                  end
               end
            end
            DATA: begin
               if (accept_d) begin
                  asm_q  <= asm_d;
                  csum_q <= csum_d;
                  if (byteCnt_q == BCW'(BYTES - 1)) begin
                     byteCnt_q  <= '0;
                     memWe_q    <= 1'b1;
                     memAddr_q  <= addr_d;
                     memWdata_q <= asm_d;
                     index_q    <= index_q + 32'd1;
                     if (index_q == count_q - 32'd1)
                        state_q <= CSUM;
                  end else begin
                     byteCnt_q <= byteCnt_q + 1'b1;
                  end
               end
            end
            CSUM: begin
               if (accept_d) begin
                  inReady_q <= 1'b0;
                  if (bus.in_data == csum_q) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     coreRstN_q <= 1'b1;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end
            end
            DONE, ERR: begin
               if (bus.restart) begin
                  state_q    <= LEN;
                  byteCnt_q  <= '0;
                  len_q      <= '0;
                  count_q    <= '0;
                  index_q    <= '0;
                  asm_q      <= '0;
                  csum_q     <= '0;
                  inReady_q  <= 1'b1;
                  coreRstN_q <= 1'b0;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
               end
            end
            default: begin
               state_q   <= LEN;
               inReady_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = inReady_q;
   assign bus.mem_we     = memWe_q;
   assign bus.mem_addr   = memAddr_q;
   assign bus.mem_wdata  = memWdata_q;
   assign bus.core_rst_n = coreRstN_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a default instance and a byte-swapped, DEPTH=4 instance
// share the clock and reset; RAM writes of each are captured into queues.
module tb_boot_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nAsserts = 0;
   int   nFails = 0;

   always #5 clk = ~clk;

   boot_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) busA ();
   boot_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) busB ();

   boot_loader dutA (.clk(clk), .rst(rst), .bus(busA));
   boot_loader #(.DEPTH(4), .BYTE_SWAP(1)) dutB (.clk(clk), .rst(rst), .bus(busB));

   logic [15:0] waA[$];
   logic [31:0] wdA[$];
   logic [15:0] waB[$];
   logic [31:0] wdB[$];

   // Every cycle with mem_we high is one write; a stretched strobe shows up as an extra entry.
   always @(negedge clk) begin
      if (busA.mem_we) begin
         waA.push_back(busA.mem_addr);
         wdA.push_back(busA.mem_wdata);
      end
      if (busB.mem_we) begin
         waB.push_back(busB.mem_addr);
         wdB.push_back(busB.mem_wdata);
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; waits (bounded) for in_ready, presents the byte for one cycle.
   task automatic applyStimulus(input int sel, input logic [7:0] b);
      int   t;
      logic rdy;
      t = 0;
      rdy = (sel == 0) ? busA.in_ready : busB.in_ready;
      while (!rdy && t < 50) begin
         @(negedge clk);
         t++;
         rdy = (sel == 0) ? busA.in_ready : busB.in_ready;
      end
      if (!rdy) begin
         nAsserts++;
         nFails++;
         $error("FAIL ready_timeout: observed in_ready 0 expected 1 (sel %0d)", sel);
      end else begin
         if (sel == 0) begin
            busA.in_valid = 1'b1;
            busA.in_data  = b;
         end else begin
            busB.in_valid = 1'b1;
            busB.in_data  = b;
         end
         @(negedge clk);
         busA.in_valid = 1'b0;
         busB.in_valid = 1'b0;
      end
   endtask

   task automatic applyImage(input int sel, input logic [7:0] img[$], input bit gaps);
      foreach (img[i]) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
         applyStimulus(sel, img[i]);
      end
   endtask

   task automatic pulseRestart(input int sel);
      if (sel == 0) busA.restart = 1'b1;
      else          busB.restart = 1'b1;
      @(negedge clk);
      busA.restart = 1'b0;
      busB.restart = 1'b0;
   endtask

   task automatic clearWrites();
      waA.delete();
      wdA.delete();
      waB.delete();
      wdB.delete();
   endtask

   initial begin
      logic [7:0] img[$];
      busA.restart = 1'b0;
      busA.in_valid = 1'b0;
      busA.in_data = 8'h00;
      busB.restart = 1'b0;
      busB.in_valid = 1'b0;
      busB.in_data = 8'h00;

      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", 64'(busA.in_ready), 64'd0);
      checkOutput("rst_mem_we", 64'(busA.mem_we), 64'd0);
      checkOutput("rst_mem_addr", 64'(busA.mem_addr), 64'd0);
      checkOutput("rst_mem_wdata", 64'(busA.mem_wdata), 64'd0);
      checkOutput("rst_core_rst_n", 64'(busA.core_rst_n), 64'd0);
      checkOutput("rst_done", 64'(busA.done), 64'd0);
      checkOutput("rst_error", 64'(busA.error), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_in_ready", 64'(busA.in_ready), 64'd1);

      $display("[TB] two-word little-endian image");
      clearWrites();
      img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
      applyImage(0, img, 1'b0);
      checkOutput("le_done", 64'(busA.done), 64'd1);
      checkOutput("le_core_rst_n", 64'(busA.core_rst_n), 64'd1);
      checkOutput("le_error", 64'(busA.error), 64'd0);
      checkOutput("le_in_ready", 64'(busA.in_ready), 64'd0);
      checkOutput("le_nwrites", 64'(waA.size()), 64'd2);
      checkOutput("le_addr0", 64'(waA[0]), 64'h0);
      checkOutput("le_data0", 64'(wdA[0]), 64'h00000013);
      checkOutput("le_addr1", 64'(waA[1]), 64'h4);
      checkOutput("le_data1", 64'(wdA[1]), 64'h0000006F);

      $display("[TB] two-word byte-swapped image");
      applyImage(1, img, 1'b0);
      checkOutput("sw_done", 64'(busB.done), 64'd1);
      checkOutput("sw_nwrites", 64'(waB.size()), 64'd2);
      checkOutput("sw_data0", 64'(wdB[0]), 64'h13000000);
      checkOutput("sw_addr1", 64'(waB[1]), 64'h4);
      checkOutput("sw_data1", 64'(wdB[1]), 64'h6F000000);

      $display("[TB] restart and one-word images, good and bad checksum");
      pulseRestart(0);
      checkOutput("restart_in_ready", 64'(busA.in_ready), 64'd1);
      checkOutput("restart_done", 64'(busA.done), 64'd0);
      checkOutput("restart_core_rst_n", 64'(busA.core_rst_n), 64'd0);
      clearWrites();
      img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      applyImage(0, img, 1'b0);
      checkOutput("one_done", 64'(busA.done), 64'd1);
      checkOutput("one_addr", 64'(waA[0]), 64'h0);
      checkOutput("one_data", 64'(wdA[0]), 64'hDDCCBBAA);
      pulseRestart(0);
      clearWrites();
      img[8] = 8'h01;
      applyImage(0, img, 1'b0);
      checkOutput("bad_error", 64'(busA.error), 64'd1);
      checkOutput("bad_done", 64'(busA.done), 64'd0);
      checkOutput("bad_core_rst_n", 64'(busA.core_rst_n), 64'd0);
      checkOutput("bad_nwrites", 64'(waA.size()), 64'd1);
      checkOutput("bad_data", 64'(wdA[0]), 64'hDDCCBBAA);

      $display("[TB] header above DEPTH");
      pulseRestart(1);
      clearWrites();
      img = '{8'h05, 8'h00, 8'h00, 8'h00};
      applyImage(1, img, 1'b0);
      checkOutput("ovf_error", 64'(busB.error), 64'd1);
      checkOutput("ovf_in_ready", 64'(busB.in_ready), 64'd0);
      checkOutput("ovf_core_rst_n", 64'(busB.core_rst_n), 64'd0);
      checkOutput("ovf_nwrites", 64'(waB.size()), 64'd0);
      pulseRestart(1);
      img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      applyImage(1, img, 1'b0);
      checkOutput("ovf_reload_done", 64'(busB.done), 64'd1);
      checkOutput("ovf_reload_error", 64'(busB.error), 64'd0);
      checkOutput("ovf_reload_data", 64'(wdB[0]), 64'h11223344);

      $display("[TB] empty image");
      pulseRestart(0);
      clearWrites();
      img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      applyImage(0, img, 1'b0);
      checkOutput("empty_done", 64'(busA.done), 64'd1);
      checkOutput("empty_nwrites", 64'(waA.size()), 64'd0);

      $display("[TB] reset mid-load with gaps, then full reload");
      pulseRestart(0);
      clearWrites();
      img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      applyImage(0, img, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_in_ready", 64'(busA.in_ready), 64'd0);
      checkOutput("midrst_done", 64'(busA.done), 64'd0);
      checkOutput("midrst_core_rst_n", 64'(busA.core_rst_n), 64'd0);
      @(negedge clk);
      checkOutput("midrst_len_ready", 64'(busA.in_ready), 64'd1);
      checkOutput("midrst_nwrites", 64'(waA.size()), 64'd1);
      checkOutput("midrst_addr", 64'(waA[0]), 64'h0);
      checkOutput("midrst_data", 64'(wdA[0]), 64'h04030201);
      clearWrites();
      img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
      applyImage(0, img, 1'b1);
      checkOutput("reload_done", 64'(busA.done), 64'd1);
      checkOutput("reload_nwrites", 64'(waA.size()), 64'd2);
      checkOutput("reload_data0", 64'(wdA[0]), 64'h04030201);
      checkOutput("reload_addr1", 64'(waA[1]), 64'h4);
      checkOutput("reload_data1", 64'(wdA[1]), 64'h08070605);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end
endmodule

// File: doc/boot_loader.md
# boot_loader

Synthesizable firmware loader that replaces the simulation-only `$fread`/`writeWord` preload path. It receives a firmware image as a byte stream (from UART/SPI front-end), reassembles words with configurable byte order, writes them into the instruction/data RAM write port, verifies an XOR checksum, and holds the core in reset until the image is loaded and verified. It sits between the byte-stream receiver and the RAM, and drives the core reset.

## Interface
- `DATA_WIDTH`, 32: RAM word width in bits; multiple of 8; BYTES = DATA_WIDTH/8.
- `ADDR_WIDTH`, 16: byte-address width of `mem_addr`.
- `DEPTH`, 4096: maximum words accepted; a header count above this is an error.
- `BASE_ADDR`, 0: byte address of word 0.
- `BYTE_SWAP`, 0: 0 = first received byte of a word goes to bits [7:0] (little-endian image); 1 = first byte goes to the MSB byte.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `restart` in 1: single-cycle pulse; from DONE or ERR, start a new load.
- `in_valid` in 1: byte-stream valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_we` out 1: one-cycle RAM write strobe.
- `mem_addr` out ADDR_WIDTH: byte address of the write.
- `mem_wdata` out DATA_WIDTH: write data.
- `core_rst_n` out 1: core reset, low while loading/error, high only in DONE.
- `done` out 1: image loaded and checksum good.
- `error` out 1: length overflow or checksum mismatch.

## Operation
- Image format: 4-byte word count N (little-endian, always, regardless of BYTE_SWAP), then N×BYTES payload bytes, then 1 checksum byte = XOR of all payload bytes.
- Byte accepted when `in_valid && in_ready`.
- States: LEN → DATA → CSUM → DONE; any failure → ERR.
- LEN: collect 4 header bytes. On 4th: N > DEPTH → ERR; N == 0 → CSUM; else → DATA, word index = 0.
- DATA: shift bytes into assembly register per BYTE_SWAP; XOR each byte into running checksum. On the BYTES-th byte of a word: issue write, index++, byte counter clears; after word N−1 → CSUM.
- CSUM: one byte; equal to running XOR → DONE, else → ERR.
- DONE: `done`=1, `core_rst_n`=1, `in_ready`=0. ERR: `error`=1, `core_rst_n`=0, `in_ready`=0. Both hold until `restart` or `rst`.
- `restart` in DONE/ERR: clear counters, checksum, flags, `core_rst_n`=0 → LEN. `restart` in LEN/DATA/CSUM is ignored.
- Address: `mem_addr` = BASE_ADDR + index×BYTES, truncated to ADDR_WIDTH (wrap, no error).
- `in_ready` = 1 in LEN, DATA, CSUM; no memory backpressure (RAM accepts a write every cycle).

## Timing
- All outputs registered. Reset values: `in_ready`=0 in reset cycle, then 1 (state LEN); `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_rst_n`=0, `done`=0, `error`=0.
- `mem_we` pulses exactly one cycle, the cycle after the final byte of a word is accepted; `mem_addr`/`mem_wdata` valid in that cycle and held after.
- Back-to-back bytes every cycle are sustained: writes at most once per BYTES cycles, never overlapped.
- `done`/`error` and `core_rst_n` change the cycle after the deciding byte (4th header byte or checksum byte) is accepted.
- After `restart`, LEN state and `in_ready`=1 in the following cycle.
- `rst` mid-load: state → LEN, all flags cleared, `core_rst_n`=0; words already written stay in RAM; a partially assembled word is discarded, never written.
- Gaps (`in_valid`=0) of any length between bytes are legal and do not alter state.

## Test plan
- Default params, stream 02 00 00 00, 13 00 00 00, 6F 00 00 00, checksum 7C → writes 0x00000013 @0, 0x0000006F @4; `done`=1, `core_rst_n`=1; total 2 `mem_we` pulses.
- BYTE_SWAP=1, same stream → writes 0x13000000 @0, 0x6F000000 @4; done.
- Header 01 00 00 00, payload AA BB CC DD, checksum 00 (correct 0x00) → done; with checksum 01 → `error`=1, `core_rst_n`=0, write still occurred.
- DEPTH=4, header 05 00 00 00 → ERR after 4th byte, no `mem_we`, `in_ready`=0; then `restart` + valid 1-word image → DONE.
- Header 00 00 00 00, checksum 00 → DONE with zero writes.
- Assert `rst` after 6 payload bytes of a 2-word image with random `in_valid` gaps → one write @0 only, loader back in LEN; full reload then completes with correct data.
